// File: rtl/glitc_clock_pkg.sv
// Shared definitions for the GLITC clock generator controller.
// Holds the controller state encoding, the bit positions inside ctrl_o,
// status_i and err_o, and the width of the phase position counter.
package glitc_clock_pkg;

   localparam int POS_W = 16;

   // ctrl_o bit positions
   localparam int CTRL_MMCM_RST  = 0;
   localparam int CTRL_PWRDWN    = 1;
   localparam int CTRL_CLKIN_SEL = 2;

   // status_i bit positions
   localparam int STAT_SYS_LOCK  = 0;
   localparam int STAT_MULT_LOCK = 1;

   // err_o bit positions
   localparam int ERR_LOCK_TIMEOUT   = 0;
   localparam int ERR_LOCK_LOST      = 1;
   localparam int ERR_PSDONE_TIMEOUT = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST_ASSERT,
      ST_WAIT_LOCK,
      ST_PS_ISSUE,
      ST_PS_WAIT
   } state_t;

endpackage

// File: rtl/glitc_sync_2ff.sv
// Two-flop synchronizer for asynchronous level signals.
// Ports:
//   clk_i    destination clock
//   rst_n_i  asynchronous active-low reset (outputs clear to 0)
//   d_i      asynchronous input bus (bits synchronized independently)
//   q_o      synchronized output, two clk_i cycles of latency
module glitc_sync_2ff #(
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d_i;
         sync_reg <= meta_reg;
      end
   end

   assign q_o = sync_reg;

endmodule

// File: rtl/glitc_clock_controller.sv
// Initiator side of the GLITC clock generator control interface.
// Sequences MMCM reset / lock acquisition (with automatic re-lock) and runs
// signed fine-phase-shift commands one PSEN/PSDONE step at a time, tracking
// the accumulated phase position. clk_i is also the generator's PSCLK, so
// PSDONE is sampled directly; only status_i is synchronized.
// Ports:
//   ctrl_o        [0] MMCM reset, [1] mult MMCM powerdown, [2] CLKIN select
//   status_i      [0] sysclk locked, [1] mult locked (asynchronous)
//   phase_ctrl_o  [0] PSEN, [1] PSINCDEC (1 = increment)
//   phase_ctrl_i  [0] PSDONE
//   mmcm_reset_req_i, pwrdwn_i, mult_sel_i   reset request / ctrl levels
//   cmd_valid_i, cmd_ready_o, cmd_steps_i    signed step command
//   busy_o, done_o, locked_o, position_o     status
//   err_o, err_clr_i                         sticky errors and clear
module glitc_clock_controller
   import glitc_clock_pkg::*;
#(
   parameter int unsigned RESET_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT   = 65535,
   parameter int unsigned PSDONE_TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   output logic [2:0]       ctrl_o,
   input  logic [1:0]       status_i,
   output logic [7:0]       phase_ctrl_o,
   input  logic [7:0]       phase_ctrl_i,
   input  logic             mmcm_reset_req_i,
   input  logic             pwrdwn_i,
   input  logic             mult_sel_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [15:0]      cmd_steps_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             locked_o,
   output logic [15:0]      position_o,
   output logic [2:0]       err_o,
   input  logic             err_clr_i
);

   logic [1:0]       status_sync;
   state_t           state_reg;
   logic [2:0]       ctrl_reg;
   logic             psen_reg, psincdec_reg, dir_reg;
   logic             cmd_ready_reg, busy_reg, done_reg, locked_reg;
   logic             rst_pending_reg;
   logic [POS_W-1:0] position_reg, remaining_reg;
   logic [2:0]       err_reg;
   logic [31:0]      timer_reg;

   logic             qual_lock, in_ps, lock_lost, mult_change;
   logic             lock_timeout, ps_timeout, psdone, step_end, go_rst;
   logic [2:0]       err_set;
   logic [POS_W-1:0] steps_abs;
   logic             unused_phase_bits;

   assign unused_phase_bits = ^phase_ctrl_i[7:1];

   glitc_sync_2ff #(.WIDTH(2)) u_status_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (status_i),
      .q_o     (status_sync)
   );

   always_comb begin
      // The multiplier lock only matters when CLKIN is taken from it.
      qual_lock    = status_sync[STAT_SYS_LOCK] &
                     (ctrl_reg[CTRL_CLKIN_SEL] ? status_sync[STAT_MULT_LOCK] : 1'b1);
      in_ps        = (state_reg == ST_PS_ISSUE) || (state_reg == ST_PS_WAIT);
      psdone       = phase_ctrl_i[0];
      lock_lost    = ((state_reg == ST_IDLE) || in_ps) && !qual_lock;
      mult_change  = (state_reg == ST_IDLE) && (mult_sel_i != ctrl_reg[CTRL_CLKIN_SEL]);
      lock_timeout = (state_reg == ST_WAIT_LOCK) && !qual_lock &&
                     (timer_reg == LOCK_TIMEOUT - 1);
      ps_timeout   = (state_reg == ST_PS_WAIT) && !psdone &&
                     (timer_reg == PSDONE_TIMEOUT - 1);
      step_end     = (state_reg == ST_PS_WAIT) && (psdone || ps_timeout);
      // Any path into a fresh reset sequence; a request raised during a
      // phase shift waits until the in-flight step resolves.
      go_rst       = lock_lost || lock_timeout ||
                     ((state_reg == ST_IDLE) && (mmcm_reset_req_i || mult_change)) ||
                     (((state_reg == ST_RST_ASSERT) || (state_reg == ST_WAIT_LOCK)) &&
                      mmcm_reset_req_i) ||
                     (step_end && (mmcm_reset_req_i || rst_pending_reg));
      err_set                     = '0;
      err_set[ERR_LOCK_TIMEOUT]   = lock_timeout;
      err_set[ERR_LOCK_LOST]      = lock_lost;
      err_set[ERR_PSDONE_TIMEOUT] = ps_timeout;
      steps_abs    = cmd_steps_i[15] ? (~cmd_steps_i + 16'd1) : cmd_steps_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg       <= ST_RST_ASSERT;
         ctrl_reg        <= 3'b001;
         psen_reg        <= 1'b0;
         psincdec_reg    <= 1'b0;
         dir_reg         <= 1'b0;
         cmd_ready_reg   <= 1'b0;
         busy_reg        <= 1'b1;
         done_reg        <= 1'b0;
         locked_reg      <= 1'b0;
         rst_pending_reg <= 1'b0;
         position_reg    <= '0;
         remaining_reg   <= '0;
         err_reg         <= '0;
         timer_reg       <= '0;
      end else begin
         done_reg <= 1'b0;
         // New error events override a coincident clear.
         err_reg  <= (err_clr_i ? 3'b000 : err_reg) | err_set;

         if (go_rst) begin
            state_reg               <= ST_RST_ASSERT;
            ctrl_reg[CTRL_MMCM_RST] <= 1'b1;
            timer_reg               <= '0;
            position_reg            <= '0;
            locked_reg              <= 1'b0;
            cmd_ready_reg           <= 1'b0;
            busy_reg                <= 1'b1;
            psen_reg                <= 1'b0;
            psincdec_reg            <= 1'b0;
            rst_pending_reg         <= 1'b0;
            done_reg                <= in_ps;   // abandoned command completes
            if (state_reg == ST_IDLE) begin
               ctrl_reg[CTRL_PWRDWN]    <= pwrdwn_i;
               ctrl_reg[CTRL_CLKIN_SEL] <= mult_sel_i;
            end
         end else begin
            if (in_ps && mmcm_reset_req_i)
               rst_pending_reg <= 1'b1;
            case (state_reg)
               ST_IDLE: begin
                  ctrl_reg[CTRL_PWRDWN] <= pwrdwn_i;
                  if (cmd_valid_i) begin
                     if (cmd_steps_i == 16'd0) begin
                        done_reg <= 1'b1;
                     end else begin
                        remaining_reg <= steps_abs;
                        dir_reg       <= ~cmd_steps_i[15];
                        psincdec_reg  <= ~cmd_steps_i[15];
                        psen_reg      <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_PS_ISSUE;
                     end
                  end
               end
               ST_RST_ASSERT: begin
                  if (timer_reg == RESET_CYCLES - 1) begin
                     ctrl_reg[CTRL_MMCM_RST] <= 1'b0;
                     timer_reg               <= '0;
                     state_reg               <= ST_WAIT_LOCK;
                  end else begin
                     timer_reg <= timer_reg + 32'd1;
                  end
               end
               ST_WAIT_LOCK: begin
                  if (qual_lock) begin
                     locked_reg    <= 1'b1;
                     cmd_ready_reg <= 1'b1;
                     busy_reg      <= 1'b0;
                     state_reg     <= ST_IDLE;
                  end else begin
                     timer_reg <= timer_reg + 32'd1;
                  end
               end
               ST_PS_ISSUE: begin
                  psen_reg  <= 1'b0;
                  timer_reg <= '0;
                  state_reg <= ST_PS_WAIT;
               end
               ST_PS_WAIT: begin
                  if (psdone) begin
                     position_reg  <= dir_reg ? position_reg + 16'd1 : position_reg - 16'd1;
                     remaining_reg <= remaining_reg - 16'd1;
                     if (remaining_reg == 16'd1) begin
                        done_reg      <= 1'b1;
                        psincdec_reg  <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                     end else begin
                        psen_reg  <= 1'b1;
                        state_reg <= ST_PS_ISSUE;
                     end
                  end else if (ps_timeout) begin
                     done_reg      <= 1'b1;
                     psincdec_reg  <= 1'b0;
                     cmd_ready_reg <= 1'b1;
                     busy_reg      <= 1'b0;
                     state_reg     <= ST_IDLE;
                  end else begin
                     timer_reg <= timer_reg + 32'd1;
                  end
               end
               default: begin
                  state_reg               <= ST_RST_ASSERT;
                  ctrl_reg[CTRL_MMCM_RST] <= 1'b1;
                  timer_reg               <= '0;
               end
            endcase
         end
      end
   end

   assign ctrl_o       = ctrl_reg;
   assign phase_ctrl_o = {6'b000000, psincdec_reg, psen_reg};
   assign cmd_ready_o  = cmd_ready_reg;
   assign busy_o       = busy_reg;
   assign done_o       = done_reg;
   assign locked_o     = locked_reg;
   assign position_o   = position_reg;
   assign err_o        = err_reg;

endmodule

// File: tb/tb_glitc_clock_controller.sv
// Directed bench for glitc_clock_controller (LOCK_TIMEOUT = 200).
module tb_glitc_clock_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  ctrl_o;
   logic [1:0]  status_i = 2'b00;
   logic [7:0]  phase_ctrl_o;
   logic [7:0]  phase_ctrl_i;
   logic        mmcm_reset_req_i = 1'b0;
   logic        pwrdwn_i = 1'b0;
   logic        mult_sel_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [15:0] cmd_steps_i = 16'd0;
   logic        busy_o, done_o, locked_o;
   logic [15:0] position_o;
   logic [2:0]  err_o;
   logic        err_clr_i = 1'b0;

   int vectors = 0;
   int errors  = 0;

   // PSDONE model and output monitors
   logic        model_en = 1'b1;
   int          psdone_cd = 0;
   int          psen_cnt = 0, inc_cnt = 0, long_cnt = 0, done_cnt = 0;
   logic        psen_prev = 1'b0;

   always #5 clk = ~clk;

   glitc_clock_controller #(.LOCK_TIMEOUT(200)) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .ctrl_o           (ctrl_o),
      .status_i         (status_i),
      .phase_ctrl_o     (phase_ctrl_o),
      .phase_ctrl_i     (phase_ctrl_i),
      .mmcm_reset_req_i (mmcm_reset_req_i),
      .pwrdwn_i         (pwrdwn_i),
      .mult_sel_i       (mult_sel_i),
      .cmd_valid_i      (cmd_valid_i),
      .cmd_ready_o      (cmd_ready_o),
      .cmd_steps_i      (cmd_steps_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .locked_o         (locked_o),
      .position_o       (position_o),
      .err_o            (err_o),
      .err_clr_i        (err_clr_i)
   );

   // PSDONE returns 12 cycles after a PSEN pulse when the model is enabled.
   always @(posedge clk) begin
      if (phase_ctrl_o[0] && model_en)
         psdone_cd <= 12;
      else if (psdone_cd > 0)
         psdone_cd <= psdone_cd - 1;
   end
   assign phase_ctrl_i = {7'b0000000, (psdone_cd == 1)};

   always @(negedge clk) begin
      if (rst_n) begin
         if (phase_ctrl_o[0]) psen_cnt <= psen_cnt + 1;
         if (phase_ctrl_o[0] && phase_ctrl_o[1]) inc_cnt <= inc_cnt + 1;
         if (phase_ctrl_o[0] && psen_prev) long_cnt <= long_cnt + 1;
         if (done_o) done_cnt <= done_cnt + 1;
      end
      psen_prev <= phase_ctrl_o[0];
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic issue_cmd(input logic [15:0] steps);
      cmd_steps_i = steps;
      cmd_valid_i = 1'b1;
      @(negedge clk);
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int limit, output logic seen);
      int k;
      k = 0;
      while (!done_o && k < limit) begin
         @(negedge clk);
         k++;
      end
      seen = done_o;
   endtask

   task automatic wait_locked(input int limit, output logic seen);
      int k;
      k = 0;
      while (!locked_o && k < limit) begin
         @(negedge clk);
         k++;
      end
      seen = locked_o;
   endtask

   task automatic test_reset;
      int cnt;
      cycles(3);
      vectors++;
      if ({ctrl_o, phase_ctrl_o, cmd_ready_o, busy_o, done_o, locked_o, position_o, err_o}
          !== {3'b001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000}) begin
         errors++;
         $display("FAIL reset_values: ctrl=%b pc=%h rdy=%b busy=%b done=%b lock=%b pos=%h err=%b",
                  ctrl_o, phase_ctrl_o, cmd_ready_o, busy_o, done_o, locked_o, position_o, err_o);
      end
      rst_n = 1'b1;
      cnt = 0;
      while (ctrl_o[0] && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      vectors++;
      if (cnt !== 16) begin
         errors++;
         $display("FAIL reset_pulse_len: got %0d cycles expected 16", cnt);
      end
      cycles(14);
      status_i = 2'b01;
      cnt = 0;
      while (!locked_o && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (!(locked_o && cnt <= 3)) begin
         errors++;
         $display("FAIL lock_latency: locked=%b after %0d cycles expected 1 within 3", locked_o, cnt);
      end
      vectors++;
      if ({cmd_ready_o, busy_o, err_o, ctrl_o} !== {1'b1, 1'b0, 3'b000, 3'b000}) begin
         errors++;
         $display("FAIL idle_after_lock: rdy=%b busy=%b err=%b ctrl=%b expected 1 0 000 000",
                  cmd_ready_o, busy_o, err_o, ctrl_o);
      end
   endtask

   task automatic test_phase_steps(input logic [15:0] steps, input int n_exp, input int inc_exp,
                                   input logic [15:0] pos_exp);
      int   p0, i0, l0, d0;
      logic seen;
      p0 = psen_cnt; i0 = inc_cnt; l0 = long_cnt; d0 = done_cnt;
      issue_cmd(steps);
      vectors++;
      if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL ps_busy: busy=%b rdy=%b expected 1 0", busy_o, cmd_ready_o);
      end
      wait_done(2000, seen);
      cycles(3);
      vectors++;
      if (!seen || (psen_cnt - p0) != n_exp || (inc_cnt - i0) != inc_exp || (long_cnt - l0) != 0) begin
         errors++;
         $display("FAIL ps_pulses: done=%b psen=%0d inc=%0d long=%0d expected 1 %0d %0d 0",
                  seen, psen_cnt - p0, inc_cnt - i0, long_cnt - l0, n_exp, inc_exp);
      end
      vectors++;
      if (position_o !== pos_exp || (done_cnt - d0) != 1) begin
         errors++;
         $display("FAIL ps_position: pos=%h dones=%0d expected %h 1", position_o, done_cnt - d0, pos_exp);
      end
   endtask

   task automatic test_psdone_timeout;
      int   p0, d0, cnt;
      model_en = 1'b0;
      p0 = psen_cnt; d0 = done_cnt;
      issue_cmd(16'd3);
      cnt = 0;
      while (!phase_ctrl_o[0] && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      cnt = 0;
      while (!err_o[2] && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (!err_o[2] || cnt < 64 || cnt > 65 || !done_o) begin
         errors++;
         $display("FAIL psdone_timeout: err=%b after %0d cycles done=%b expected err[2] at 64..65 with done",
                  err_o, cnt, done_o);
      end
      cycles(3);
      vectors++;
      if (position_o !== 16'hFFFE || (psen_cnt - p0) != 1 || (done_cnt - d0) != 1 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_state: pos=%h psen=%0d dones=%0d rdy=%b expected fffe 1 1 1",
                  position_o, psen_cnt - p0, done_cnt - d0, cmd_ready_o);
      end
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      vectors++;
      if (err_o !== 3'b000) begin
         errors++;
         $display("FAIL err_clear: err=%b expected 000", err_o);
      end
      model_en = 1'b1;
   endtask

   task automatic test_lock_loss;
      int   d0, k, cnt;
      logic seen;
      d0 = done_cnt;
      issue_cmd(16'd10);
      k = 0;
      while (position_o !== 16'h0001 && k < 500) begin
         @(negedge clk);
         k++;
      end
      status_i = 2'b00;
      wait_done(50, seen);
      vectors++;
      if (!seen || err_o !== 3'b010 || locked_o !== 1'b0 || ctrl_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL lock_loss: done=%b err=%b lock=%b ctrl=%b expected 1 010 0 xx1",
                  seen, err_o, locked_o, ctrl_o);
      end
      cnt = 0;
      while (ctrl_o[0] && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      vectors++;
      if (cnt !== 16 || position_o !== 16'h0000) begin
         errors++;
         $display("FAIL relock_reset: pulse=%0d pos=%h expected 16 0000", cnt, position_o);
      end
      status_i = 2'b01;
      wait_locked(20, seen);
      cycles(2);
      vectors++;
      if (!seen || err_o !== 3'b010 || (done_cnt - d0) != 1) begin
         errors++;
         $display("FAIL relock: lock=%b err=%b dones=%0d expected 1 010 1", seen, err_o, done_cnt - d0);
      end
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
   endtask

   task automatic test_mult_sel;
      int   cnt;
      logic seen;
      mult_sel_i = 1'b1;
      cnt = 0;
      while (!err_o[0] && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      vectors++;
      if (!err_o[0] || cnt < 215 || cnt > 219) begin
         errors++;
         $display("FAIL lock_timeout: err=%b after %0d cycles expected err[0] at 215..219", err_o, cnt);
      end
      vectors++;
      if (ctrl_o !== 3'b101 || locked_o !== 1'b0) begin
         errors++;
         $display("FAIL lock_retry: ctrl=%b lock=%b expected 101 0", ctrl_o, locked_o);
      end
      status_i = 2'b11;
      wait_locked(300, seen);
      vectors++;
      if (!seen || ctrl_o !== 3'b100 || err_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL mult_lock: lock=%b ctrl=%b err=%b expected 1 100 err[0]=1", seen, ctrl_o, err_o);
      end
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
   endtask

   task automatic test_back_to_back;
      int   p0, d0;
      logic seen;
      p0 = psen_cnt; d0 = done_cnt;
      mmcm_reset_req_i = 1'b1;
      issue_cmd(16'd5);
      mmcm_reset_req_i = 1'b0;
      vectors++;
      if (ctrl_o[0] !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL req_wins: ctrl=%b busy=%b expected xx1 1", ctrl_o, busy_o);
      end
      wait_locked(100, seen);
      cycles(2);
      vectors++;
      if (!seen || (psen_cnt - p0) != 0 || (done_cnt - d0) != 0 || position_o !== 16'h0000) begin
         errors++;
         $display("FAIL req_no_cmd: lock=%b psen=%0d dones=%0d pos=%h expected 1 0 0 0000",
                  seen, psen_cnt - p0, done_cnt - d0, position_o);
      end
      issue_cmd(16'd0);
      vectors++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL zero_done: done=%b expected 1", done_o);
      end
      cycles(4);
      vectors++;
      if (done_o !== 1'b0 || (psen_cnt - p0) != 0 || (done_cnt - d0) != 1 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL zero_cmd: done=%b psen=%0d dones=%0d rdy=%b expected 0 0 1 1",
                  done_o, psen_cnt - p0, done_cnt - d0, cmd_ready_o);
      end
   endtask

   initial begin
      test_reset;
      test_phase_steps(16'd5, 5, 5, 16'h0005);
      test_phase_steps(16'hFFF9, 7, 0, 16'hFFFE);
      test_psdone_timeout;
      test_lock_loss;
      test_mult_sel;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
